matrix_result_ascii_serializer: RTL
===================================

// Module: matrix_result_ascii_serializer
// PURPOSE
//  Writer side of the golden-vector line format: captures one complex 4x4 result
//  (C_real/C_imag from matrix_mult_4x4_complex_alphaevolve) and streams it as ASCII
//  '0'/'1' text, one char per handshake. Sits between the multiplier and a UART/log
//  sink so on-board results can be diffed against Matlab golden files with existing tools.
//  Each value is sign-extended to FIELD_W bits and sent MSB first. Separators go
//  between fields, and the line ends with a newline.
// PARAMETERS
//  w          16        input operand width of the multiplier
//  WIDTH_OUT  2*w+3     width of each C element (35 by default)
//  FIELD_W    128       chars per value; must be >= WIDTH_OUT
//  SEP_CHAR   8'h2C     field separator (',')
// PORTS
//  clk        in   1              single clock, rising edge
//  rst        in   1              asynchronous, active-high reset
//  in_valid   in   1              a C matrix is offered
//  in_ready   out  1              block can capture a matrix
//  c_real     in   16*WIDTH_OUT   element (i,j) at [(4*i+j)*WIDTH_OUT +: WIDTH_OUT], signed
//  c_imag     in   16*WIDTH_OUT   same layout as c_real
//  char_data  out  8              ASCII character
//  char_valid out  1              char_data is valid
//  char_ready in   1              sink accepts char_data
//  busy       out  1              a line is being emitted
//  line_done  out  1              one-cycle pulse after the newline is accepted
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - State=IDLE, all counters 0.
//   - char_valid=0, char_data=8'h00, busy=0, line_done=0; in_ready=1.
//  Capture: when in_valid && in_ready at edge N, register both matrices.
//   - in_ready=0 from N+1. Inputs are don't-care after capture.
//  Line order: elements row-major, (0,0),(0,1)..(3,3). For each element: real field,
//   SEP_CHAR, imag field, then SEP_CHAR except after the last imag field.
//   - Last imag field is followed by 8'h0A.
//   - Line length = 32*FIELD_W + 31 + 1 = 4128 chars at defaults.
//  Field: the value sign-extended to FIELD_W bits. Bit FIELD_W-1 is sent first as
//   8'h31 ('1') or 8'h30 ('0').
//  FSM:
//   - IDLE -> BITS on capture.
//   - BITS -> SEP after the last bit is accepted, unless it is field 31.
//   - BITS -> EOL after the last bit of field 31 is accepted.
//   - SEP -> BITS once the separator is accepted.
//   - EOL -> IDLE once the newline is accepted.
//  Counters:
//   - bit_cnt 0..FIELD_W-1
//   - field_cnt 0..31; even = real, odd = imag, element = field_cnt>>1
//  Handshake (valid/ready):
//   - Output is registered; first char is valid at N+1.
//   - char_data/char_valid stay stable while char_valid && !char_ready.
//   - Counters advance only on char_valid && char_ready.
//   - With char_ready held high: 1 char/cycle, no bubbles inside a line.
//  Completion:
//   - line_done is high for exactly the cycle after the newline transfer.
//   - In that same cycle: state=IDLE, in_ready=1, busy=0, char_valid=0.
//   - The next capture can happen in that cycle, so the line gap is 1 cycle.
//  in_valid while busy: ignored, no capture, no effect on the current line.
//  busy = (state != IDLE).
//  char_ready while char_valid=0: ignored.
//  Reset mid-line: the line is abandoned immediately; char_valid drops asynchronously.
//   After release, the next capture restarts at field 0, bit FIELD_W-1.
//  No arithmetic beyond sign extension. The MSB of each element is replicated
//   into bits FIELD_W-1..WIDTH_OUT.
// TESTING
//  1 Reset, then idle 5 cycles -> in_ready=1, char_valid=0, busy=0, line_done=0;
//    char_ready toggling has no effect.
//  2 All zeros except Cr[0][0]=1, char_ready=1:
//    - Chars 0..126 '0', char 127 '1', char 128 ','.
//    - 4128 chars total, last 8'h0A; line_done one cycle later.
//  3 Cr[0][0]=-1 and Ci[3][3]=-2^34:
//    - Field 0 is 128x'1'.
//    - Field 31 is 94x'1' then 34x'0', followed by '\n'.
//  4 Backpressure: char_ready pseudo-random 50%, including 5 low cycles mid-field:
//    - char_data stable while stalled; no lost or duplicate chars.
//    - Stream is identical to test 2.
//  5 in_valid held with a second matrix during a line -> not captured until the
//    line_done cycle; the second line follows with a 1-cycle gap.
//  6 Assert rst at char 200 -> char_valid=0 at once. After release, a new capture
//    emits from char 0; a parse-back of the line equals the driven matrix.

Source files
------------

// File: rtl/matrix_result_ascii_serializer.sv
// Streams one captured complex 4x4 result matrix as a single ASCII text line:
// each element's real and imaginary values sign-extended to FIELD_W '0'/'1' chars,
// MSB first, comma separated, newline terminated. One char per valid/ready transfer.
module matrix_result_ascii_serializer #(
    parameter int unsigned w         = 16,
    parameter int unsigned WIDTH_OUT = 2 * w + 3,
    parameter int unsigned FIELD_W   = 128,
    parameter logic [7:0]  SEP_CHAR  = 8'h2C
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [16*WIDTH_OUT-1:0] c_real,
    input  logic [16*WIDTH_OUT-1:0] c_imag,
    output logic [7:0]              char_data,
    output logic                    char_valid,
    input  logic                    char_ready,
    output logic                    busy,
    output logic                    line_done
);

    localparam int unsigned     BitW      = (FIELD_W > 1) ? $clog2(FIELD_W) : 1;
    localparam logic [BitW-1:0] LastBit   = BitW'(FIELD_W - 1);
    localparam logic [4:0]      LastField = 5'd31;

    typedef enum logic [1:0] {StIdle, StBits, StSep, StEol} state_e;

    state_e                   r_state;
    state_e                   w_state_d;
    logic [BitW-1:0]          r_bit_cnt;
    logic [BitW-1:0]          w_bit_d;
    logic [4:0]               r_field_cnt;
    logic [4:0]               w_field_d;
    logic [16*WIDTH_OUT-1:0]  r_c_real;
    logic [16*WIDTH_OUT-1:0]  r_c_imag;
    logic [16*WIDTH_OUT-1:0]  w_real_d;
    logic [16*WIDTH_OUT-1:0]  w_imag_d;
    logic [7:0]               r_char_data;
    logic [7:0]               w_char_d;
    logic                     r_char_valid;
    logic                     r_line_done;
    logic                     w_line_done_d;
    logic                     w_fire;
    int unsigned              w_base;
    logic [WIDTH_OUT-1:0]     w_elem;
    logic [FIELD_W-1:0]       w_field_val;
    logic [BitW-1:0]          w_pos;

    assign w_fire     = r_char_valid && char_ready;
    assign in_ready   = (r_state == StIdle);
    assign busy       = (r_state != StIdle);
    assign char_data  = r_char_data;
    assign char_valid = r_char_valid;
    assign line_done  = r_line_done;

    // Next-state: capture in idle, then walk bits/separators/newline on each transfer.
    always_comb begin
        w_state_d     = r_state;
        w_bit_d       = r_bit_cnt;
        w_field_d     = r_field_cnt;
        w_real_d      = r_c_real;
        w_imag_d      = r_c_imag;
        w_line_done_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_state_d = StBits;
                    w_bit_d   = '0;
                    w_field_d = '0;
                    w_real_d  = c_real;
                    w_imag_d  = c_imag;
                end
            end
            StBits: begin
                if (w_fire) begin
                    if (r_bit_cnt == LastBit) begin
                        w_bit_d   = '0;
                        w_state_d = (r_field_cnt == LastField) ? StEol : StSep;
                    end else begin
                        w_bit_d = r_bit_cnt + 1'b1;
                    end
                end
            end
            StSep: begin
                if (w_fire) begin
                    w_state_d = StBits;
                    w_field_d = r_field_cnt + 1'b1;
                end
            end
            StEol: begin
                if (w_fire) begin
                    w_state_d     = StIdle;
                    w_field_d     = '0;
                    w_line_done_d = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Character for the next cycle, derived from next-state values so the output can be
    // registered without adding a cycle of latency after capture or after each transfer.
    always_comb begin
        w_base      = 32'(w_field_d[4:1]) * WIDTH_OUT;
        w_elem      = w_field_d[0] ? w_imag_d[w_base +: WIDTH_OUT]
                                   : w_real_d[w_base +: WIDTH_OUT];
        w_field_val = FIELD_W'($signed(w_elem));
        w_pos       = LastBit - w_bit_d;
        w_char_d    = 8'h00;
        unique case (w_state_d)
            StBits:  w_char_d = w_field_val[w_pos] ? 8'h31 : 8'h30;
            StSep:   w_char_d = SEP_CHAR;
            StEol:   w_char_d = 8'h0A;
            default: w_char_d = 8'h00;
        endcase
    end

    // State, counters, captured matrices and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_bit_cnt    <= '0;
            r_field_cnt  <= '0;
            r_c_real     <= '0;
            r_c_imag     <= '0;
            r_char_data  <= 8'h00;
            r_char_valid <= 1'b0;
            r_line_done  <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_bit_cnt    <= w_bit_d;
            r_field_cnt  <= w_field_d;
            r_c_real     <= w_real_d;
            r_c_imag     <= w_imag_d;
            r_char_data  <= w_char_d;
            r_char_valid <= (w_state_d != StIdle);
            r_line_done  <= w_line_done_d;
        end
    end

endmodule
